// File: rtl/dbus_responder_stub_pkg.sv
// Shared debug-bus definitions: op/response codes, default field widths and
// the responder FSM state encoding. Imported by the transport and responder.
package dbus_pkg;

  localparam int DBUS_DATA_BITS_DEF = 34;
  localparam int DBUS_ADDR_BITS_DEF = 5;
  localparam int DBUS_OP_BITS_DEF   = 2;
  localparam int LAT_CNT_BITS       = 4;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_RSVD  = 2'd3
  } dbus_op_e;

  // BUSY is owned by the transport; the responder never produces it.
  typedef enum logic [1:0] {
    RESP_OK   = 2'd0,
    RESP_FAIL = 2'd2,
    RESP_BUSY = 2'd3
  } dbus_resp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dbus_state_e;

endpackage

// File: rtl/dbus_responder_stub_if.sv
// Request/response handshake between the debug transport (master) and the
// debug-bus responder (slave). Request = {addr, data, op}, response = {data, resp}.
interface dbus_responder_stub_if
  import dbus_pkg::*;
#(
  parameter int DATA_BITS = DBUS_DATA_BITS_DEF,
  parameter int ADDR_BITS = DBUS_ADDR_BITS_DEF,
  parameter int OP_BITS   = DBUS_OP_BITS_DEF
) ();

  logic                              dtm_req_valid;
  logic                              dtm_req_ready;
  logic [ADDR_BITS+DATA_BITS+OP_BITS-1:0] dtm_req_data;
  logic                              dtm_resp_valid;
  logic                              dtm_resp_ready;
  logic [DATA_BITS+OP_BITS-1:0]      dtm_resp_data;

  modport master (
    output dtm_req_valid, dtm_req_data, dtm_resp_ready,
    input  dtm_req_ready, dtm_resp_valid, dtm_resp_data
  );

  modport slave (
    input  dtm_req_valid, dtm_req_data, dtm_resp_ready,
    output dtm_req_ready, dtm_resp_valid, dtm_resp_data
  );

endinterface

// File: rtl/dbus_responder_stub_regfile.sv
// Debug register file: NUM_WORDS words, asynchronous clear, one write port,
// combinational execute and observation read ports (0 when unmapped).
module dbus_regfile
  import dbus_pkg::*;
#(
  parameter int DATA_BITS = DBUS_DATA_BITS_DEF,
  parameter int ADDR_BITS = DBUS_ADDR_BITS_DEF,
  parameter int NUM_WORDS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data,
  input  logic [ADDR_BITS-1:0] obs_addr,
  output logic [DATA_BITS-1:0] obs_data
);

  logic [DATA_BITS-1:0] mem_q [NUM_WORDS];
  logic [DATA_BITS-1:0] mem_d [NUM_WORDS];

  // Next memory contents: only the addressed word takes the write data
  always_comb begin
    for (int i = 0; i < NUM_WORDS; i++) begin
      mem_d[i] = mem_q[i];
      if (wr_en && (wr_addr == ADDR_BITS'(i))) mem_d[i] = wr_data;
    end
  end

  // Memory storage, cleared asynchronously with the debug reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WORDS; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_WORDS; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Both read ports: full-width address match, unmapped addresses read 0
  always_comb begin
    rd_data  = '0;
    obs_data = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (rd_addr == ADDR_BITS'(i))  rd_data  = mem_q[i];
      if (obs_addr == ADDR_BITS'(i)) obs_data = mem_q[i];
    end
  end

endmodule

// File: rtl/dbus_responder_stub.sv
// Debug-bus responder running in the TCK domain: accepts one request at a
// time, executes it against the register file at accept, and presents the
// response after RESP_LATENCY cycles (stretched by resp_stall).
module dbus_responder_stub
  import dbus_pkg::*;
#(
  parameter int DEBUG_DATA_BITS = DBUS_DATA_BITS_DEF,
  parameter int DEBUG_ADDR_BITS = DBUS_ADDR_BITS_DEF,
  parameter int DEBUG_OP_BITS   = DBUS_OP_BITS_DEF,
  parameter int NUM_WORDS       = 32,
  parameter int RESP_LATENCY    = 2
) (
  input  logic                       TCK,
  input  logic                       TRST,
  dbus_responder_stub_if.slave       dbus,
  input  logic                       resp_stall,
  input  logic                       force_fail,
  input  logic [DEBUG_ADDR_BITS-1:0] obs_addr,
  output logic [DEBUG_DATA_BITS-1:0] obs_data
);

  localparam int RESP_W = DEBUG_DATA_BITS + DEBUG_OP_BITS;
  localparam logic [DEBUG_ADDR_BITS:0]  NUM_WORDS_W = (DEBUG_ADDR_BITS+1)'(NUM_WORDS);
  localparam logic [LAT_CNT_BITS-1:0]   LAT_LOAD    = LAT_CNT_BITS'(RESP_LATENCY);
  localparam logic [DEBUG_OP_BITS-1:0]  OP_CODE_NOP   = DEBUG_OP_BITS'(OP_NOP);
  localparam logic [DEBUG_OP_BITS-1:0]  OP_CODE_READ  = DEBUG_OP_BITS'(OP_READ);
  localparam logic [DEBUG_OP_BITS-1:0]  OP_CODE_WRITE = DEBUG_OP_BITS'(OP_WRITE);
  localparam logic [DEBUG_OP_BITS-1:0]  RESP_CODE_OK   = DEBUG_OP_BITS'(RESP_OK);
  localparam logic [DEBUG_OP_BITS-1:0]  RESP_CODE_FAIL = DEBUG_OP_BITS'(RESP_FAIL);

  dbus_state_e               state_q, state_d;
  logic [LAT_CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [RESP_W-1:0]         resp_data_q, resp_data_d;

  logic [DEBUG_OP_BITS-1:0]   req_op;
  logic [DEBUG_DATA_BITS-1:0] req_wdata;
  logic [DEBUG_ADDR_BITS-1:0] req_addr;
  logic [DEBUG_DATA_BITS-1:0] rd_data;
  logic [RESP_W-1:0]          exec_resp;
  logic                       accept;
  logic                       addr_mapped;
  logic                       wr_en;

  assign req_op    = dbus.dtm_req_data[DEBUG_OP_BITS-1:0];
  assign req_wdata = dbus.dtm_req_data[DEBUG_OP_BITS +: DEBUG_DATA_BITS];
  assign req_addr  = dbus.dtm_req_data[DEBUG_OP_BITS+DEBUG_DATA_BITS +: DEBUG_ADDR_BITS];

  assign accept      = dbus.dtm_req_valid && (state_q == ST_IDLE);
  assign addr_mapped = {1'b0, req_addr} < NUM_WORDS_W;

  dbus_regfile #(
    .DATA_BITS (DEBUG_DATA_BITS),
    .ADDR_BITS (DEBUG_ADDR_BITS),
    .NUM_WORDS (NUM_WORDS)
  ) u_regfile (
    .clk      (TCK),
    .rst      (TRST),
    .wr_en    (wr_en),
    .wr_addr  (req_addr),
    .wr_data  (req_wdata),
    .rd_addr  (req_addr),
    .rd_data  (rd_data),
    .obs_addr (obs_addr),
    .obs_data (obs_data)
  );

  // Execute the presented request: build the response word and write enable
  always_comb begin
    exec_resp = '0;
    wr_en     = 1'b0;
    if (force_fail) begin
      exec_resp = {{DEBUG_DATA_BITS{1'b0}}, RESP_CODE_FAIL};
    end else if ((req_op == OP_CODE_READ) && addr_mapped) begin
      exec_resp = {rd_data, RESP_CODE_OK};
    end else if ((req_op == OP_CODE_WRITE) && addr_mapped) begin
      exec_resp = {req_wdata, RESP_CODE_OK};
      wr_en     = accept;
    end else if (req_op != OP_CODE_NOP) begin
      // Reserved op, or READ/WRITE to an unmapped address
      exec_resp = {{DEBUG_DATA_BITS{1'b0}}, RESP_CODE_FAIL};
    end
  end

  // State, latency counter and response holding register
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      resp_data_q <= resp_data_d;
    end
  end

  // Next state: accept in IDLE, count down in WAIT, hand off in RESP
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    resp_data_d = resp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          resp_data_d = exec_resp;
          cnt_d       = LAT_LOAD;
          state_d     = (RESP_LATENCY == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!resp_stall) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == LAT_CNT_BITS'(1)) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (dbus.dtm_resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state
  always_comb begin
    dbus.dtm_req_ready  = 1'b0;
    dbus.dtm_resp_valid = 1'b0;
    case (state_q)
      ST_IDLE: dbus.dtm_req_ready  = 1'b1;
      ST_RESP: dbus.dtm_resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign dbus.dtm_resp_data = resp_data_q;

endmodule
